// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU sequencer: data width, opcodes, FSM encodings.
// Pure declarations; no timing or flow-control behaviour lives here.
package alu_arbiter_pkg;

  localparam int DW = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU; zero latency, no flow control.
// Results wrap modulo 2^8; b is unused for NOT and the single-bit shifts.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    s,
  output logic [DW-1:0] out
);

  always_comb begin
    out = '0;
    case (s)
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_XOR: out = a ^ b;
      ALU_NOT: out = ~a;
      ALU_SHL: out = {a[DW-2:0], 1'b0};
      ALU_SHR: out = {1'b0, a[DW-1:1]};
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester ALU sequencer; response valid two cycles after accept.
// Response is held while rsp_ready is low and no new request is accepted until it drains.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero
);

  state_t        state;
  logic          prio;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    op_q;
  logic          id_q;
  logic [DW-1:0] alu_out;
  logic          can_accept;
  logic          gnt0;
  logic          gnt1;

  // Ready is gated by rst so a requester never sees a grant while the block is held in reset.
  assign can_accept = (state == ST_IDLE) && !rst;
  assign gnt0       = can_accept && req0_valid && (!req1_valid || !prio);
  assign gnt1       = can_accept && req1_valid && (!req0_valid ||  prio);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  alu u_alu (
    .a   (a_q),
    .b   (b_q),
    .s   (op_q),
    .out (alu_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prio      <= FIRST_PRIO;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_ADD;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            a_q   <= gnt1 ? req1_a  : req0_a;
            b_q   <= gnt1 ? req1_b  : req0_b;
            op_q  <= gnt1 ? req1_op : req0_op;
            id_q  <= gnt1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= (alu_out == '0);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // Priority only rotates once the consumer has actually taken the result.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            prio      <= ~id_q;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic
// checked against an arithmetic reference model and a round-robin grant model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [7:0] rsp_data;

  alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic id; logic [7:0] data; } rsp_t;

  rsp_t       exp_q[$];
  logic       log_id[$];
  logic [7:0] log_data[$];
  int         checks = 0;
  int         failures = 0;
  int         rsp_count = 0;
  logic       prio_m = 1'b0;
  logic       hold = 1'b0;
  rsp_t       held;
  logic       held_zero;
  logic       rnd_on;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a * 2;
      default: r = a / 2;
    endcase
    return r[7:0];
  endfunction

  // Monitor: grant fairness, exclusivity, hold stability, and response scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_during_reset", int'(req0_ready | req1_ready), 0);
      exp_q.delete();
      prio_m = 1'b0;
      hold   = 1'b0;
    end else begin
      chk("ready_exclusive", int'(req0_ready & req1_ready), 0);
      if (hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_id", rsp_id, held.id);
        chk("hold_data", rsp_data, held.data);
        chk("hold_zero", rsp_zero, held_zero);
      end
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        chk("rr_grant", req1_ready, prio_m);
      if (req0_valid && req0_ready) exp_q.push_back({1'b0, ref_alu(req0_a, req0_b, req0_op)});
      if (req1_valid && req1_ready) exp_q.push_back({1'b1, ref_alu(req1_a, req1_b, req1_op)});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("sb_id", rsp_id, e.id);
          chk("sb_data", rsp_data, e.data);
          chk("sb_zero", rsp_zero, int'(e.data == 8'h00));
          prio_m = ~e.id;
        end
        log_id.push_back(rsp_id);
        log_data.push_back(rsp_data);
        rsp_count++;
      end
      hold      = rsp_valid && !rsp_ready;
      held      = {rsp_id, rsp_data};
      held_zero = rsp_zero;
    end
  end

  task automatic drive(input bit id, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n;
    n = 0;
    @(posedge clk); #1;
    drive(id, 1'b1, a, b, op);
    do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 400);
    if (n >= 400) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_count(input int target);
    int k;
    k = 0;
    while (rsp_count < target && k < 400) begin @(negedge clk); k++; end
    if (rsp_count < target) chk("rsp_timeout", rsp_count, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    logic [7:0] sweep_exp [8];
    sweep_exp = '{8'hB4, 8'h96, 8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h4A, 8'h52};
    rst = 1'b1; rsp_ready = 1'b1; rnd_on = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 3'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_zero", rsp_zero, 0);

    // Single ADD with latency checks.
    @(posedge clk); #1 drive(1'b0, 1'b1, 8'h0F, 8'h01, ALU_ADD);
    @(negedge clk); chk("add_ready", req0_ready, 1); chk("add_no_rsp_yet", rsp_valid, 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk); chk("add_ready_one_cycle", req0_ready, 0); chk("add_exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("add_rsp_valid", rsp_valid, 1); chk("add_rsp_id", rsp_id, 0);
    chk("add_rsp_data", rsp_data, 8'h10); chk("add_rsp_zero", rsp_zero, 0);
    wait_count(1);

    // Wrap to zero and borrow.
    n = rsp_count; issue(1'b1, 8'hFF, 8'h01, ALU_ADD); wait_count(n + 1);
    chk("wrap_id", log_id[n], 1); chk("wrap_data", log_data[n], 8'h00);
    n = rsp_count; issue(1'b0, 8'h00, 8'h01, ALU_SUB); wait_count(n + 1);
    chk("borrow_data", log_data[n], 8'hFF);

    // Simultaneous requests after reset; second req0 must wait behind pending req1.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n = rsp_count;
    fork
      begin issue(1'b0, 8'hF0, 8'h3C, ALU_AND); issue(1'b0, 8'h0F, 8'hF0, ALU_OR); end
      issue(1'b1, 8'h81, 8'h00, ALU_SHR);
    join
    wait_count(n + 3);
    chk("both_first_id", log_id[n], 0);     chk("both_first_data", log_data[n], 8'h30);
    chk("both_second_id", log_id[n+1], 1);  chk("both_second_data", log_data[n+1], 8'h40);
    chk("both_third_id", log_id[n+2], 0);   chk("both_third_data", log_data[n+2], 8'hFF);

    // Backpressure: response held, req1 blocked, accepted right after the handshake.
    n = rsp_count; rsp_ready = 1'b0;
    issue(1'b0, 8'h12, 8'h34, ALU_XOR);
    drive(1'b1, 1'b1, 8'h03, 8'h05, ALU_ADD);
    k = 0;
    while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
    chk("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, 8'h26);
      chk("bp_req1_blocked", req1_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); chk("bp_req1_wait_hs", req1_ready, 0);
    @(negedge clk); chk("bp_req1_after_hs", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_count(n + 2);
    chk("bp_second_id", log_id[n+1], 1); chk("bp_second_data", log_data[n+1], 8'h08);

    // Reset during EXEC: op dropped, priority back to requester 0.
    n = rsp_count; issue(1'b0, 8'h01, 8'h01, ALU_ADD); wait_count(n + 1);
    n = rsp_count;
    @(posedge clk); #1 drive(1'b0, 1'b1, 8'h55, 8'h11, ALU_ADD);
    @(negedge clk); chk("rst_op_ready", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0; rst = 1'b1; drive(1'b1, 1'b1, 8'h22, 8'h00, ALU_NOT);
    @(negedge clk); chk("rst_req1_ready", req1_ready, 0);
    @(posedge clk); #1 rst = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);   chk("rst_rsp_zero", rsp_zero, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_rsp", rsp_count, n);
    fork
      issue(1'b0, 8'hC3, 8'h00, ALU_NOT);
      issue(1'b1, 8'h7F, 8'h01, ALU_ADD);
    join
    wait_count(n + 2);
    chk("rst_prio_id", log_id[n], 0);   chk("rst_prio_data", log_data[n], 8'h3C);
    chk("rst_next_id", log_id[n+1], 1); chk("rst_next_data", log_data[n+1], 8'h80);

    // Opcode sweep.
    for (int i = 0; i < 8; i++) begin
      n = rsp_count; issue(1'b0, 8'hA5, 8'h0F, 3'(i)); wait_count(n + 1);
      chk("sweep_data", log_data[n], sweep_exp[i]);
    end

    // Randomized traffic with random backpressure.
    rnd_on = 1'b1;
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(1'b0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
          end
          for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
          end
        join
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk); #1 rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
